// File: rtl/n64_joybus_pkg.sv
// Shared Joybus constants, command codes, frame lengths and receiver state encoding.
// Used by both the Rx and Tx stages.
package n64_joybus_pkg;

    localparam int LEVEL_WIDTH = 2;
    localparam int BIT_WIDTH   = 4 * LEVEL_WIDTH;

    localparam logic [7:0] CMD_INFO      = 8'h00;
    localparam logic [7:0] CMD_STATUS    = 8'h01;
    localparam logic [7:0] CMD_READ_ACC  = 8'h02;
    localparam logic [7:0] CMD_WRITE_ACC = 8'h03;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    localparam int FRAME_BYTES_DEFAULT = 1;
    localparam int FRAME_BYTES_READ    = 3;
    localparam int FRAME_BYTES_WRITE   = 35;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SAMPLE,
        RX_WAIT_EDGE,
        RX_STOP,
        TX_OWNED
    } rx_state_t;

    // Total data bits expected in a frame that starts with command c.
    function automatic logic [8:0] frame_bits_for(input logic [7:0] c);
        case (c)
            CMD_READ_ACC:  return 9'(FRAME_BYTES_READ * 8);
            CMD_WRITE_ACC: return 9'(FRAME_BYTES_WRITE * 8);
            default:       return 9'(FRAME_BYTES_DEFAULT * 8);
        endcase
    endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the raw Joybus line with falling/rising edge detect.
// Everything resets high so an idle line never produces a spurious edge.
module n64_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line,
    output logic fall,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign line = s2;
    assign fall = prev & ~s2;
    assign rise = ~prev & s2;

endmodule

// File: rtl/n64_controller_rx.sv
// Joybus receive stage: decodes console frames, exposes command/address/payload,
// then hands line ownership to the Tx stage until it toggles rx_handoff back.
module n64_controller_rx
    import n64_joybus_pkg::*;
#(
    parameter int LEVEL_WIDTH  = n64_joybus_pkg::LEVEL_WIDTH,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        data_rx,
    input  logic        rx_handoff,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        frame_error
);

    // level_cnt reads 0 on the cycle after a falling edge, so "edge + N cycles" is N-1.
    localparam logic [15:0] CNT_SAMPLE  = 16'(2 * LEVEL_WIDTH - 1);
    localparam logic [15:0] CNT_TIMEOUT = 16'(IDLE_TIMEOUT - 1);

    rx_state_t   state;
    rx_state_t   state_next;

    logic        line;
    logic        fall;
    logic        rise;

    logic [15:0] level_cnt;
    logic [8:0]  bit_cnt;
    logic [8:0]  frame_bits;
    logic [7:0]  shreg;
    logic        handoff_cap;

    logic        frame_start;
    logic        bit_start;
    logic        sample;
    logic        abort;
    logic        enter_tx;
    logic        leave_tx;

    logic [7:0]  shift_next;
    logic [8:0]  bit_cnt_next;
    logic        byte_done;
    logic [5:0]  byte_idx;
    logic        addr_cmd;

    n64_line_sync u_sync (
        .clk   (sample_clk),
        .reset (reset),
        .din   (data_rx),
        .line  (line),
        .fall  (fall),
        .rise  (rise)
    );

    assign shift_next   = {shreg[6:0], line};
    assign bit_cnt_next = bit_cnt + 9'd1;
    assign byte_done    = (bit_cnt_next[2:0] == 3'd0);
    assign byte_idx     = bit_cnt_next[8:3] - 6'd1;
    assign addr_cmd     = (cmd == CMD_READ_ACC) || (cmd == CMD_WRITE_ACC);

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        bit_start   = 1'b0;
        sample      = 1'b0;
        abort       = 1'b0;
        enter_tx    = 1'b0;
        leave_tx    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    frame_start = 1'b1;
                    state_next  = RX_SAMPLE;
                end
            end
            RX_SAMPLE: begin
                if (level_cnt == CNT_SAMPLE) begin
                    sample     = 1'b1;
                    state_next = RX_WAIT_EDGE;
                end
            end
            RX_WAIT_EDGE: begin
                if (fall) begin
                    bit_start  = 1'b1;
                    state_next = (bit_cnt == frame_bits) ? RX_STOP : RX_SAMPLE;
                end else if (level_cnt == CNT_TIMEOUT) begin
                    abort      = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            RX_STOP: begin
                // The line is low on entry, so the first high cycle is always a rise.
                if (rise) begin
                    enter_tx   = 1'b1;
                    state_next = TX_OWNED;
                end else if (level_cnt == CNT_TIMEOUT) begin
                    abort      = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            TX_OWNED: begin
                if (rx_handoff != handoff_cap) begin
                    leave_tx   = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state         <= RX_IDLE;
            level_cnt     <= '0;
            bit_cnt       <= '0;
            frame_bits    <= 9'd8;
            shreg         <= '0;
            handoff_cap   <= 1'b0;
            cur_operation <= 1'b0;
            cmd           <= '0;
            addr          <= '0;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_next;
            payload_valid <= 1'b0;
            frame_error   <= abort;

            if (frame_start || bit_start) begin
                level_cnt <= '0;
            end else if (state == RX_SAMPLE || state == RX_WAIT_EDGE || state == RX_STOP) begin
                level_cnt <= level_cnt + 16'd1;
            end

            if (frame_start) begin
                bit_cnt    <= '0;
                frame_bits <= 9'd8;
            end

            if (sample) begin
                shreg   <= shift_next;
                bit_cnt <= bit_cnt_next;
                if (byte_done) begin
                    case (byte_idx)
                        6'd0: begin
                            cmd        <= shift_next;
                            frame_bits <= frame_bits_for(shift_next);
                        end
                        6'd1: if (addr_cmd) addr[15:8] <= shift_next;
                        6'd2: if (addr_cmd) addr[7:0]  <= shift_next;
                        default: begin
                            if (cmd == CMD_WRITE_ACC) begin
                                payload_data  <= shift_next;
                                payload_valid <= 1'b1;
                            end
                        end
                    endcase
                end
            end

            if (enter_tx) begin
                cur_operation <= 1'b1;
                handoff_cap   <= rx_handoff;
            end else if (leave_tx) begin
                cur_operation <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_n64_controller_rx.sv
// Directed bench for n64_controller_rx: drives Joybus frames on data_rx and
// scoreboards the write payload against bytes queued at send time.
module tb_n64_controller_rx;

    localparam int LW = 2;
    localparam int TO = 16;

    logic        sample_clk = 1'b0;
    logic        reset;
    logic        data_rx;
    logic        rx_handoff;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        frame_error;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int pay_cnt = 0;
    logic [7:0] exp_q[$];

    n64_controller_rx #(
        .LEVEL_WIDTH  (LW),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .sample_clk    (sample_clk),
        .reset         (reset),
        .data_rx       (data_rx),
        .rx_handoff    (rx_handoff),
        .cur_operation (cur_operation),
        .cmd           (cmd),
        .addr          (addr),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .frame_error   (frame_error)
    );

    always #5 sample_clk = ~sample_clk;

    // Output monitor on the opposite edge: error pulses and payload scoreboard.
    always @(negedge sample_clk) begin
        if (frame_error) err_cnt++;
        if (payload_valid) begin
            pay_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL payload_unexpected observed=%0h expected=none", payload_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert (payload_data === e) else begin
                    bad++;
                    $error("FAIL payload observed=%0h expected=%0h", payload_data, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        data_rx = 1'b0;
        tick(b ? LW : 3 * LW);
        data_rx = 1'b1;
        tick(b ? 3 * LW : LW);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Stop bit plus the 3-cycle ownership latency check from the raw rising edge.
    task automatic send_stop(input string tag);
        data_rx = 1'b0;
        tick(LW);
        data_rx = 1'b1;
        tick(2);
        check({tag, "_curop_early"}, 32'(cur_operation), 32'd0);
        tick(1);
        check({tag, "_curop_lat3"}, 32'(cur_operation), 32'd1);
    endtask

    task automatic release_tx(input string tag);
        rx_handoff = ~rx_handoff;
        tick(1);
        check({tag, "_release"}, 32'(cur_operation), 32'd0);
        tick(4);
    endtask

    initial begin
        int p0;
        int e0;

        reset      = 1'b1;
        data_rx    = 1'b1;
        rx_handoff = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_curop", 32'(cur_operation), 32'd0);
        check("rst_cmd",   32'(cmd),           32'd0);
        check("rst_addr",  32'(addr),          32'd0);
        check("rst_pdata", 32'(payload_data),  32'd0);
        check("rst_pvalid",32'(payload_valid), 32'd0);
        check("rst_ferr",  32'(frame_error),   32'd0);

        // Status command: single-byte frame, no payload.
        p0 = pay_cnt;
        send_byte(8'h01);
        check("st_curop_before_stop", 32'(cur_operation), 32'd0);
        send_stop("st");
        check("st_cmd",    32'(cmd),     32'h01);
        check("st_nopay",  32'(pay_cnt), 32'(p0));
        check("st_noerr",  32'(err_cnt), 32'd0);
        release_tx("st");

        // Write accessory: address plus 32 payload bytes.
        p0 = pay_cnt;
        send_byte(8'h03);
        send_byte(8'h80);
        send_byte(8'h01);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i));
        end
        check("wr_curop_before_stop", 32'(cur_operation), 32'd0);
        send_stop("wr");
        check("wr_cmd",     32'(cmd),          32'h03);
        check("wr_addr",    32'(addr),         32'h8001);
        check("wr_paycnt",  32'(pay_cnt - p0), 32'd32);
        check("wr_qempty",  32'(exp_q.size()), 32'd0);

        // Line activity while Tx owns it must be ignored.
        for (int i = 0; i < 4; i++) begin
            data_rx = 1'b0;
            tick(LW);
            data_rx = 1'b1;
            tick(3 * LW);
        end
        check("tx_hold_curop", 32'(cur_operation), 32'd1);
        check("tx_hold_cmd",   32'(cmd),           32'h03);
        check("tx_hold_err",   32'(err_cnt),       32'd0);
        release_tx("wr");

        // Truncated read-accessory frame: timeout abort, cmd/addr retained.
        e0 = err_cnt;
        send_byte(8'h02);
        send_byte(8'h5A);
        tick(6);
        check("to_not_early", 32'(err_cnt - e0), 32'd0);
        tick(10);
        check("to_once",  32'(err_cnt - e0), 32'd1);
        tick(20);
        check("to_single",32'(err_cnt - e0), 32'd1);
        check("to_cmd",   32'(cmd),           32'h02);
        check("to_addr",  32'(addr),          32'h5A01);
        check("to_curop", 32'(cur_operation), 32'd0);

        // Unknown command: one-byte frame; also proves the receiver is back in idle.
        send_byte(8'h7E);
        send_stop("unk");
        check("unk_cmd", 32'(cmd), 32'h7E);
        release_tx("unk");

        // Reset mid-frame: no error pulse, partial frame discarded.
        e0 = err_cnt;
        send_byte(8'h03);
        send_bit(1'b1);
        send_bit(1'b0);
        data_rx = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        data_rx = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("mr_cmd",   32'(cmd),           32'd0);
        check("mr_addr",  32'(addr),          32'd0);
        check("mr_curop", 32'(cur_operation), 32'd0);
        tick(30);
        check("mr_noerr", 32'(err_cnt - e0), 32'd0);
        p0 = pay_cnt;
        send_byte(8'hFF);
        send_stop("ff");
        check("ff_cmd",   32'(cmd),          32'hFF);
        check("ff_nopay", 32'(pay_cnt - p0), 32'd0);
        check("ff_noerr", 32'(err_cnt - e0), 32'd0);
        release_tx("ff");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n64_controller_rx.md
N64_CONTROLLER_RX -- requirements
Module: n64_controller_rx

Interface
REQ-001 Parameter LEVEL_WIDTH, default 2, is the sample_clk cycles per Joybus level.
REQ-002 Parameter IDLE_TIMEOUT, default 16, is the sample_clk cycles without a falling edge before a pending frame is aborted.
REQ-003 sample_clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_rx  input  1  raw, asynchronous Joybus line; idle high.
REQ-006 rx_handoff  input  1  toggle from the Tx stage; any change means Tx is done.
REQ-007 cur_operation  output  1  0 = Rx owns the line, 1 = Tx owns it.
REQ-008 cmd  output  8  last received command byte.
REQ-009 addr  output  16  address bytes of the last 0x02/0x03 command, MSB first.
REQ-010 payload_data  output  8  write-payload byte.
REQ-011 payload_valid  output  1  one-cycle strobe qualifying payload_data.
REQ-012 frame_error  output  1  one-cycle strobe on an aborted frame.

Function
REQ-013 data_rx shall pass through a 2-flop synchronizer (reset value 1) before any use; "line" below means its output.
REQ-014 A falling edge shall be line 1 in the previous cycle and 0 in the current cycle.
REQ-015 States: RX_IDLE, RX_SAMPLE, RX_WAIT_EDGE, RX_STOP, TX_OWNED.
REQ-016 RX_IDLE: cur_operation=0; on a falling edge, clear bit count and level counter and go to RX_SAMPLE.
REQ-017 RX_SAMPLE: increment the level counter each cycle; at count 2*LEVEL_WIDTH (falling-edge cycle = 0), shift line into the byte register MSB-first, increment the bit count, and go to RX_WAIT_EDGE.
REQ-018 A sample of 1 decodes as logical 1 (L,H,H,H); a sample of 0 decodes as logical 0 (L,L,L,H).
REQ-019 On the 8th bit of byte 0, cmd shall update on the same sample edge, and the expected frame length shall latch as 3 bytes for 0x02, 35 bytes for 0x03, and 1 byte otherwise, including 0x00/0xFF/0x01 and unknown codes.
REQ-020 Bytes 1 and 2 of a 0x02/0x03 frame shall load addr[15:8] and addr[7:0] respectively.
REQ-021 Bytes 3..34 of a 0x03 frame shall each present payload_data with payload_valid=1 for exactly one cycle, on the cycle after the byte's 8th sample.
REQ-022 RX_WAIT_EDGE: count cycles since the last falling edge.
  - Falling edge with bits still expected: go to RX_SAMPLE.
  - Falling edge with all expected bits received: this is the stop bit; go to RX_STOP.
  - Count reaching IDLE_TIMEOUT: pulse frame_error and go to RX_IDLE.
REQ-023 RX_STOP: on the first cycle with line=1, go to TX_OWNED.
  - On that transition, set cur_operation=1 and capture rx_handoff.
  - Stop-bit timeout shall be treated as in REQ-022.
REQ-024 TX_OWNED: ignore line; when rx_handoff differs from the captured value, set cur_operation=0 and go to RX_IDLE on the next cycle.
REQ-025 Latency: cur_operation shall rise 3 cycles after the raw data_rx rising edge of the stop bit (2 synchronizer cycles + 1 register cycle).
REQ-026 The bit counter shall be 9 bits wide (max 280 bits + stop) and shall not wrap within a legal frame.
REQ-027 cmd and addr shall hold their values until overwritten; a frame_error shall not clear them.
REQ-028 A glitch low for less than 2*LEVEL_WIDTH cycles decodes as 1; no separate glitch rejection is required.

Reset
REQ-029 reset shall force RX_IDLE, cur_operation=0, cmd=0, addr=0, payload_data=0, payload_valid=0, frame_error=0, synchronizer=1, and all counters to 0 on the next posedge.
REQ-030 Reset asserted mid-frame or in TX_OWNED shall discard the partial frame with no frame_error pulse.

Structure
REQ-031 Package n64_joybus_pkg shall hold LEVEL_WIDTH, BIT_WIDTH (4*LEVEL_WIDTH), the command codes 0x00/0x01/0x02/0x03/0xFF, the frame lengths, and the state encoding, shared with the Tx stage.
REQ-032 One sub-module, n64_line_sync (synchronizer plus falling/rising edge detect), shall be instantiated.

Verification
REQ-033 Send 0x01 plus stop bit at LEVEL_WIDTH=2 -> cmd=0x01, cur_operation=1 exactly 3 cycles after the stop rising edge, no payload_valid.
REQ-034 Send 0x03, addr 0x8001, 32 bytes 0x00..0x1F, stop -> addr=0x8001, 32 payload_valid strobes carrying 0x00..0x1F in order, then cur_operation=1.
REQ-035 Send 0x02 and only the first address byte, then hold the line high -> frame_error pulses once IDLE_TIMEOUT=16 cycles after the last falling edge, state returns to RX_IDLE, cmd=0x02 is retained.
REQ-036 With cur_operation=1, toggle rx_handoff -> cur_operation=0 within 1 cycle; falling edges while in TX_OWNED before the toggle are ignored.
REQ-037 Assert reset mid-byte of a 0x03 frame, then send 0xFF -> no frame_error, cmd=0xFF, frame length 1 byte.
REQ-038 Send unknown 0x7E -> treated as a 1-byte frame, cur_operation=1 after the stop bit.
